// File: rtl/jam_cost_responder.sv
// Stand-in for the JAM cost ROM: serial table load, JAM reset sequencing,
// registered cost lookup and result checking against golden values.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   ld_valid/ld_data  serial table load, row-major (index = W*8+J)
//   gold_min_cost     expected MinCost (latched at end of load)
//   gold_match_count  expected MatchCount (latched at end of load)
//   W, J              lookup index from JAM
//   Valid, MinCost,
//   MatchCount        result strobe and payload from JAM
//   Cost              table[{W,J}] one cycle after W/J are sampled
//   jam_rst           reset driven to JAM
//   done/pass/timeout run outcome flags
//   cycle_cnt         RUN cycles elapsed
module jam_cost_responder #(
  parameter int COST_W         = 7,
  parameter int RST_HOLD       = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  input  logic [9:0]        gold_min_cost,
  input  logic [3:0]        gold_match_count,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic [COST_W-1:0] Cost,
  output logic              jam_rst,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycle_cnt
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [5:0]        idx;
  logic [HW-1:0]     hold_cnt;
  logic [9:0]        gold_min_q;
  logic [3:0]        gold_cnt_q;
  logic [COST_W-1:0] cost_tbl [64];

  // Table storage carries no reset; it is only written while loading.
  always_ff @(posedge CLK) begin
    if (!RST && state == S_LOAD && ld_valid) begin
      cost_tbl[idx] <= ld_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_LOAD;
      idx        <= '0;
      hold_cnt   <= '0;
      Cost       <= '0;
      jam_rst    <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      gold_min_q <= '0;
      gold_cnt_q <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          Cost    <= '0;
          jam_rst <= 1'b1;
          if (ld_valid) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              state      <= S_HOLD;
              hold_cnt   <= '0;
              gold_min_q <= gold_min_cost;
              gold_cnt_q <= gold_match_count;
            end
          end
        end
        S_HOLD: begin
          Cost <= cost_tbl[{W, J}];
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            jam_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          Cost <= cost_tbl[{W, J}];
          // Valid wins over a timeout on the same boundary cycle.
          if (Valid) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
            pass    <= (MinCost == gold_min_q) &&
                       (MatchCount == gold_cnt_q);
            if (cycle_cnt != '1) begin
              cycle_cnt <= cycle_cnt + 32'd1;
            end
          end else if (cycle_cnt == CNT_LAST) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end
        S_DONE: begin
          Cost <= cost_tbl[{W, J}];
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_responder.sv
// Self-checking bench for jam_cost_responder: table vectors, random
// lookups against a model table, and pass/fail/timeout/reset sequences.
module tb_jam_cost_responder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ld_valid;
  logic [6:0] ld_data;
  logic [9:0] gold_min_cost;
  logic [3:0] gold_match_count;
  logic [2:0] W;
  logic [2:0] J;
  logic       Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic [6:0] Cost;
  logic       jam_rst;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [31:0] cycle_cnt;

  int total = 0;
  int bad = 0;

  logic [6:0] mdl [64];

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    int         exp;
  } vec_t;

  vec_t vecs [8];

  always #5 CLK = ~CLK;

  jam_cost_responder #(
    .COST_W(7),
    .RST_HOLD(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .gold_min_cost(gold_min_cost),
    .gold_match_count(gold_match_count),
    .W(W),
    .J(J),
    .Valid(Valid),
    .MinCost(MinCost),
    .MatchCount(MatchCount),
    .Cost(Cost),
    .jam_rst(jam_rst),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int ref_cost(input int w, input int j);
    return int'(mdl[w * 8 + j]);
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    ld_valid = 1'b0;
    Valid = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic load_table(input bit gaps);
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        ld_valid = 1'b0;
        ld_data = 7'h55;
        step();
        chk("load_gap_cost", 32'(Cost), 0);
        chk("load_gap_rst", 32'(jam_rst), 1);
      end
      ld_valid = 1'b1;
      ld_data = mdl[i];
      step();
      chk("load_cost", 32'(Cost), 0);
      chk("load_rst", 32'(jam_rst), 1);
    end
    ld_valid = 1'b0;
  endtask

  // Two HOLD cycles; optional junk strobes must not reach the table.
  task automatic hold_seq(input bit junk);
    int w0;
    int j0;
    w0 = $urandom_range(0, 7);
    j0 = $urandom_range(0, 7);
    W = 3'(w0);
    J = 3'(j0);
    ld_valid = junk;
    ld_data = 7'(~mdl[w0 * 8 + j0]);
    step();
    chk("hold1_rst", 32'(jam_rst), 1);
    chk("hold_lookup", 32'(Cost), 32'(ref_cost(w0, j0)));
    ld_data = 7'($urandom);
    step();
    chk("hold2_rst", 32'(jam_rst), 0);
    chk("run0_cnt", cycle_cnt, 0);
    ld_valid = 1'b0;
  endtask

  task automatic lookups(input int n);
    int w0;
    int j0;
    for (int k = 0; k < n; k++) begin
      w0 = $urandom_range(0, 7);
      j0 = $urandom_range(0, 7);
      W = 3'(w0);
      J = 3'(j0);
      step();
      chk("rand_lookup", 32'(Cost), 32'(ref_cost(w0, j0)));
    end
  endtask

  task automatic rand_table();
    for (int i = 0; i < 64; i++) mdl[i] = 7'($urandom);
  endtask

  initial begin
    int n;
    vecs[0] = '{3'd3, 3'd5, 29};
    vecs[1] = '{3'd7, 3'd7, 63};
    vecs[2] = '{3'd0, 3'd0, 0};
    vecs[3] = '{3'd1, 3'd0, 8};
    vecs[4] = '{3'd0, 3'd7, 7};
    vecs[5] = '{3'd6, 3'd2, 50};
    vecs[6] = '{3'd4, 3'd4, 36};
    vecs[7] = '{3'd2, 3'd6, 22};

    RST = 1'b1;
    ld_valid = 1'b0;
    ld_data = '0;
    gold_min_cost = 10'd252;
    gold_match_count = 4'd8;
    W = '0;
    J = '0;
    Valid = 1'b0;
    MinCost = '0;
    MatchCount = '0;
    step();
    step();
    chk("rst_jam_rst", 32'(jam_rst), 1);
    chk("rst_cost", 32'(Cost), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cnt", cycle_cnt, 0);
    RST = 1'b0;

    // Identity table, gapped load, pass at RUN cycle 40.
    for (int i = 0; i < 64; i++) mdl[i] = 7'(i);
    load_table(1'b1);
    hold_seq(1'b0);
    foreach (vecs[v]) begin
      W = vecs[v].w;
      J = vecs[v].j;
      step();
      chk("vec_cost", 32'(Cost), 32'(vecs[v].exp));
    end
    chk("run8_cnt", cycle_cnt, 8);
    lookups(32);
    chk("run40_cnt", cycle_cnt, 40);
    Valid = 1'b1;
    MinCost = 10'd252;
    MatchCount = 4'd8;
    step();
    Valid = 1'b0;
    chk("pass_done", 32'(done), 1);
    chk("pass_pass", 32'(pass), 1);
    chk("pass_timeout", 32'(timeout), 0);
    chk("pass_cnt", cycle_cnt, 41);
    Valid = 1'b1;
    MinCost = 10'd1;
    MatchCount = 4'd0;
    step();
    Valid = 1'b0;
    lookups(3);
    chk("pass2_done", 32'(done), 1);
    chk("pass2_pass", 32'(pass), 1);
    chk("pass2_cnt", cycle_cnt, 41);
    chk("done_jam_rst", 32'(jam_rst), 0);

    // Fail: MatchCount off by one.
    do_reset();
    chk("rerst_done", 32'(done), 0);
    rand_table();
    load_table(1'b0);
    hold_seq(1'b0);
    lookups(10);
    Valid = 1'b1;
    MinCost = 10'd252;
    MatchCount = 4'd7;
    step();
    Valid = 1'b0;
    chk("fail_done", 32'(done), 1);
    chk("fail_pass", 32'(pass), 0);
    chk("fail_timeout", 32'(timeout), 0);

    // Fail: MinCost differs only in bit 9.
    do_reset();
    load_table(1'b0);
    hold_seq(1'b0);
    Valid = 1'b1;
    MinCost = 10'd252 ^ 10'h200;
    MatchCount = 4'd8;
    step();
    Valid = 1'b0;
    chk("fail9_pass", 32'(pass), 0);

    // Timeout with no Valid.
    do_reset();
    rand_table();
    load_table(1'b0);
    hold_seq(1'b0);
    n = 0;
    while (!done && n < 200) begin
      W = 3'($urandom);
      J = 3'($urandom);
      step();
      n++;
    end
    chk("to_edges", 32'(n), 100);
    chk("to_done", 32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_cnt", cycle_cnt, 99);
    lookups(2);

    // Valid on the boundary cycle wins.
    do_reset();
    gold_min_cost = 10'd513;
    gold_match_count = 4'd15;
    load_table(1'b0);
    hold_seq(1'b0);
    lookups(99);
    chk("b_done_pre", 32'(done), 0);
    chk("b_cnt_pre", cycle_cnt, 99);
    Valid = 1'b1;
    MinCost = 10'd513;
    MatchCount = 4'd15;
    step();
    Valid = 1'b0;
    chk("b_done", 32'(done), 1);
    chk("b_pass", 32'(pass), 1);
    chk("b_timeout", 32'(timeout), 0);

    // Reset mid-run, then reload with junk strobes in HOLD.
    do_reset();
    load_table(1'b0);
    hold_seq(1'b1);
    lookups(20);
    chk("mid_cnt", cycle_cnt, 20);
    W = 3'd7;
    J = 3'd7;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_jam_rst", 32'(jam_rst), 1);
    chk("mid_cost", 32'(Cost), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_cnt0", cycle_cnt, 0);
    rand_table();
    load_table(1'b0);
    hold_seq(1'b1);
    lookups(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
